cmp_seq2: RTL and testbench

- Multi-cycle magnitude comparator for the ALU compare path.
- Consumes W-bit operands two bits (one digit) per clock, MSB digit first, using the 2-bit greater-than slice function on each digit.
- Produces registered agtb/aeqb/altb flags with a start/ready/done_tick handshake for the ALU control FSM.
- Trades latency for area versus a flat W-bit comparator and terminates early on the first differing digit.

---
 rtl/cmp_seq2.sv | 101 ++++++++++
 tb/tb_cmp_seq2.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq2.sv
// Digit-serial unsigned magnitude comparator: two bits per clock, MSB digit first,
// early exit on the first differing digit, start/ready/done_tick handshake.
module cmp_seq2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic         agtb,
  output logic         aeqb,
  output logic         altb
);

  localparam int D  = W / 2;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(D - 1);

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  sa, sb, sa_nx, sb_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          gt_nx, eq_nx, lt_nx;
  logic          dgt, dlt;

  // 2-bit greater-than slice; used both ways round to get the less-than decision
  function automatic logic gt2(input logic [1:0] x, input logic [1:0] y);
    return (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
  endfunction

  assign dgt       = gt2(sa[W-1 -: 2], sb[W-1 -: 2]);
  assign dlt       = gt2(sb[W-1 -: 2], sa[W-1 -: 2]);
  assign ready     = (state == IDLE);
  assign done_tick = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      agtb  <= 1'b0;
      aeqb  <= 1'b0;
      altb  <= 1'b0;
    end else begin
      state <= state_nx;
      sa    <= sa_nx;
      sb    <= sb_nx;
      cnt   <= cnt_nx;
      agtb  <= gt_nx;
      aeqb  <= eq_nx;
      altb  <= lt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sa_nx    = sa;
    sb_nx    = sb;
    cnt_nx   = cnt;
    gt_nx    = agtb;
    eq_nx    = aeqb;
    lt_nx    = altb;
    case (state)
      IDLE: begin
        if (start) begin
          sa_nx    = a;
          sb_nx    = b;
          cnt_nx   = CNT_LOAD;
          gt_nx    = 1'b0;
          eq_nx    = 1'b0;
          lt_nx    = 1'b0;
          state_nx = OP;
        end
      end
      OP: begin
        if (dgt) begin
          gt_nx    = 1'b1;
          state_nx = DONE;
        end else if (dlt) begin
          lt_nx    = 1'b1;
          state_nx = DONE;
        end else if (cnt == '0) begin
          eq_nx    = 1'b1;
          state_nx = DONE;
        end else begin
          sa_nx  = sa << 2;
          sb_nx  = sb << 2;
          cnt_nx = cnt - CW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmp_seq2.sv
// Bench for cmp_seq2 (W=8): vector table plus handshake corner sequences;
// expected flags/latency are queued at issue time and checked on done_tick.
module tb_cmp_seq2;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done_tick, agtb, aeqb, altb;

  cmp_seq2 #(.W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done_tick (done_tick),
    .agtb      (agtb),
    .aeqb      (aeqb),
    .altb      (altb)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] flags;  // {agtb, aeqb, altb}
    int         i;      // first differing digit, 3 when equal
  } vec_t;

  typedef struct {
    logic [2:0]  flags;
    int unsigned i;
    int unsigned k;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int first_diff(input logic [7:0] x, input logic [7:0] y);
    for (int d = 0; d < 4; d++)
      if (x[7-2*d -: 2] != y[7-2*d -: 2]) return d;
    return 3;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [7:0] x, input logic [7:0] y);
    return {x > y, x == y, x < y};
  endfunction

  always @(negedge clk) begin
    if (reset_n && done_tick) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done_tick=1 expected 0 (t=%0t)", $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("flags", 32'({agtb, aeqb, altb}), 32'(mon_e.flags));
        chk("latency", cyc - mon_e.k, 1 + mon_e.i);
        chk("ready_in_done", 32'(ready), 32'd0);
      end
    end else if (reset_n && !ready) begin
      chk("flags_clear_in_op", 32'({agtb, aeqb, altb}), 32'd0);
    end
  end

  // Caller is #1 after a posedge with the DUT idle; returns #1 after accepting edge k.
  task automatic issue(input logic [7:0] va, input logic [7:0] vb,
                       input logic [2:0] f, input int i);
    exp_t e;
    @(posedge clk); #1;
    a = va; b = vb; start = 1'b1;
    e.flags = f; e.i = i; e.k = cyc + 1;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || !ready) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(sbq.size() == 0 && ready), 32'd1);
  endtask

  vec_t vt[10];
  logic [7:0] ra, rb;
  int unsigned k0;

  initial begin
    vt[0] = '{8'hA5, 8'hA5, 3'b010, 3};
    vt[1] = '{8'hC0, 8'h40, 3'b100, 0};
    vt[2] = '{8'h00, 8'hFF, 3'b001, 0};
    vt[3] = '{8'h12, 8'h13, 3'b001, 3};
    vt[4] = '{8'hFF, 8'hFE, 3'b100, 3};
    vt[5] = '{8'h7F, 8'h80, 3'b001, 0};
    vt[6] = '{8'h34, 8'h38, 3'b001, 2};
    vt[7] = '{8'h9C, 8'h98, 3'b100, 2};
    vt[8] = '{8'h5A, 8'h4A, 3'b100, 1};
    vt[9] = '{8'h00, 8'h00, 3'b010, 3};

    // reset, then idle with start low
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done_tick), 32'd0);
    chk("rst_flags", 32'({agtb, aeqb, altb}), 32'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_flags", 32'({agtb, aeqb, altb, done_tick}), 32'd0);
    end

    // table-driven vectors, with flag hold check after return to idle
    for (int v = 0; v < 10; v++) begin
      issue(vt[v].a, vt[v].b, vt[v].flags, vt[v].i);
      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("flags_hold", 32'({agtb, aeqb, altb}), 32'(vt[v].flags));
    end

    // random operands, often sharing leading digits
    for (int v = 0; v < 12; v++) begin
      ra = 8'($urandom);
      rb = ra;
      rb[2*$urandom_range(0, 3) +: 2] = 2'($urandom);
      issue(ra, rb, ref_flags(ra, rb), first_diff(ra, rb));
      wait_idle();
    end

    // start pulse while busy must be ignored
    issue(8'h12, 8'h13, 3'b001, 3);
    @(posedge clk); #1;
    a = 8'h00; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("busy_ignored_flags", 32'({agtb, aeqb, altb}), 32'b001);
    chk("busy_ignored_ready", 32'(ready), 32'd1);

    // start held high: one accept every i+3 = 3 cycles
    @(posedge clk); #1;
    a = 8'hC0; b = 8'h40; start = 1'b1;
    k0 = cyc + 1;
    for (int r = 0; r < 3; r++) begin
      exp_t e;
      e.flags = 3'b100; e.i = 0; e.k = k0 + 3 * r;
      sbq.push_back(e);
    end
    repeat (7) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // reset during the second OP cycle aborts with no done_tick
    issue(8'hA5, 8'hA5, 3'b010, 3);
    @(posedge clk); #3;
    reset_n = 1'b0;
    sbq.delete();
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_flags", 32'({agtb, aeqb, altb}), 32'd0);
    chk("abort_done", 32'(done_tick), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_idle", 32'({ready, done_tick}), 32'b10);
    issue(8'h7F, 8'h80, 3'b001, 0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
